alu_arbiter: RTL and testbench

//   Shares one registered ALU (sub-module alu) between two requesters, e.g. the
//   CSM datapath (port 0) and a debug/monitor port (port 1).

---
 rtl/alu_arbiter_pkg.sv | 14 +
 rtl/alu_arbiter_alu.sv | 36 +++
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes and widths for the arbitrated ALU slice.
package alu_arbiter_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] NO_OP = 4'h0;
  localparam logic [OP_W-1:0] ADD   = 4'h1;
  localparam logic [OP_W-1:0] SUB   = 4'h2;
  localparam logic [OP_W-1:0] AND   = 4'h4;
  localparam logic [OP_W-1:0] OR    = 4'h5;
  localparam logic [OP_W-1:0] XOR   = 4'h6;
  localparam logic [OP_W-1:0] ROL   = 4'h8;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Registered ALU: one-cycle latency, result register is not reset.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic [WIDTH-1:0] o_res
);

  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;

  always_comb begin
    res_d = i_arg0;
    case (i_op)
      ADD:     res_d = i_arg0 + i_arg1;
      SUB:     res_d = i_arg0 - i_arg1;
      AND:     res_d = i_arg0 & i_arg1;
      OR:      res_d = i_arg0 | i_arg1;
      XOR:     res_d = i_arg0 ^ i_arg1;
      ROL:     res_d = {i_arg0[WIDTH-2:0], i_arg0[WIDTH-1]};
      default: res_d = i_arg0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    res_q <= res_d;
  end

  assign o_res = res_q;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one registered ALU between two requesters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [OP_W-1:0]  i_req0_op,
  input  logic [WIDTH-1:0] i_req0_arg0,
  input  logic [WIDTH-1:0] i_req0_arg1,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [OP_W-1:0]  i_req1_op,
  input  logic [WIDTH-1:0] i_req1_arg0,
  input  logic [WIDTH-1:0] i_req1_arg1,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [WIDTH-1:0] a1_q, a1_d;

  logic pick0;
  logic pick1;
  logic rsp_ack;

  // Both valid: the side that did not win last time goes next.
  assign pick0 = i_req0_valid & (~i_req1_valid | last_q);
  assign pick1 = i_req1_valid & (~i_req0_valid | ~last_q);
  assign rsp_ack = gnt_q ? i_rsp1_ready : i_rsp0_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    op_q <= op_d;
    a0_q <= a0_d;
    a1_q <= a1_d;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    case (state_q)
      S_IDLE: begin
        if (pick0 | pick1) begin
          state_d = S_EXEC;
          gnt_d   = pick1;
          op_d    = pick1 ? i_req1_op   : i_req0_op;
          a0_d    = pick1 ? i_req1_arg0 : i_req0_arg0;
          a1_d    = pick1 ? i_req1_arg1 : i_req0_arg1;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_DONE: begin
        if (rsp_ack) begin
          state_d = S_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = (state_q == S_IDLE) & pick0;
    o_req1_ready = (state_q == S_IDLE) & pick1;
    o_rsp0_valid = (state_q == S_DONE) & ~gnt_q;
    o_rsp1_valid = (state_q == S_DONE) & gnt_q;
    o_busy       = (state_q != S_IDLE);
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_clk  (i_clk),
    .i_op   (op_q),
    .i_arg0 (a0_q),
    .i_arg1 (a1_q),
    .o_res  (o_rsp_data)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: queued requests, per-port expected results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] exp;
  } req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a0 = '0, req0_a1 = '0;
  logic [7:0] req1_a0 = '0, req1_a1 = '0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  req_t       rq0[$], rq1[$];
  logic [7:0] exp0[$], exp1[$];
  int         glog[$], rlog[$];
  bit         hs0 = 0, hs1 = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req0_valid),
    .o_req0_ready (req0_ready),
    .i_req0_op    (req0_op),
    .i_req0_arg0  (req0_a0),
    .i_req0_arg1  (req0_a1),
    .i_req1_valid (req1_valid),
    .o_req1_ready (req1_ready),
    .i_req1_op    (req1_op),
    .i_req1_arg0  (req1_a0),
    .i_req1_arg1  (req1_a1),
    .o_rsp0_valid (rsp0_valid),
    .i_rsp0_ready (rsp0_ready),
    .o_rsp1_valid (rsp1_valid),
    .i_rsp1_ready (rsp1_ready),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy)
  );

  function automatic logic [7:0] alu_ref(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h4:    return a & b;
      4'h5:    return a | b;
      4'h6:    return a ^ b;
      4'h8:    return {a[6:0], a[7]};
      default: return a;
    endcase
  endfunction

  // Requester drivers: present queue heads, retire on accepted handshake.
  always begin
    @(posedge clk);
    #1;
    if (hs0 && rq0.size() > 0) void'(rq0.pop_front());
    if (hs1 && rq1.size() > 0) void'(rq1.pop_front());
    hs0 = 0;
    hs1 = 0;
    if (rq0.size() > 0) begin
      req0_valid = 1'b1;
      req0_op = rq0[0].op; req0_a0 = rq0[0].a0; req0_a1 = rq0[0].a1;
    end else req0_valid = 1'b0;
    if (rq1.size() > 0) begin
      req1_valid = 1'b1;
      req1_op = rq1[0].op; req1_a0 = rq1[0].a0; req1_a1 = rq1[0].a1;
    end else req1_valid = 1'b0;
  end

  // Monitor: record grants, score responses.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (req0_valid && req0_ready && rq0.size() > 0) begin
        hs0 = 1; exp0.push_back(rq0[0].exp); glog.push_back(0);
      end
      if (req1_valid && req1_ready && rq1.size() > 0) begin
        hs1 = 1; exp1.push_back(rq1[0].exp); glog.push_back(1);
      end
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
        checks++; errors++;
        $display("FAIL both_rsp_valid: rsp0=1 rsp1=1 required one-hot");
      end
      if (rsp0_valid === 1'b1 && rsp0_ready) begin
        checks++;
        rlog.push_back(0);
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL rsp0_unexpected: data=%h with no pending op", rsp_data);
        end else begin
          e = exp0.pop_front();
          if (rsp_data !== e) begin
            errors++;
            $display("FAIL rsp0_data: got %h required %h", rsp_data, e);
          end
        end
      end
      if (rsp1_valid === 1'b1 && rsp1_ready) begin
        checks++;
        rlog.push_back(1);
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL rsp1_unexpected: data=%h with no pending op", rsp_data);
        end else begin
          e = exp1.pop_front();
          if (rsp_data !== e) begin
            errors++;
            $display("FAIL rsp1_data: got %h required %h", rsp_data, e);
          end
        end
      end
    end
  end

  task automatic push0(input logic [3:0] op, input logic [7:0] a, b, e);
    req_t r;
    r.op = op; r.a0 = a; r.a1 = b; r.exp = e;
    rq0.push_back(r);
  endtask

  task automatic push1(input logic [3:0] op, input logic [7:0] a, b, e);
    req_t r;
    r.op = op; r.a0 = a; r.a1 = b; r.exp = e;
    rq1.push_back(r);
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    rq0.delete(); rq1.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    exp0.delete(); exp1.delete();
    glog.delete(); rlog.delete();
    hs0 = 0; hs1 = 0;
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (rq0.size() == 0 && rq1.size() == 0 && exp0.size() == 0 &&
          exp1.size() == 0 && !busy && !req0_valid && !req1_valid) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b rdy0=%b rdy1=%b required 0 0 0",
               busy, req0_ready, req1_ready);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: v0=%b v1=%b required 0 0", rsp0_valid, rsp1_valid);
    end
  endtask

  task automatic test_latency();
    bit ok;
    bit seen = 0;
    push0(ADD, 8'h7F, 8'h01, 8'h80);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_grant: seen=%b busy=%b required 1 0", seen, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_exec: busy=%b v0=%b rdy0=%b required 1 0 0",
               busy, rsp0_valid, req0_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_data !== 8'h80 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_done: v0=%b data=%h busy=%b required 1 80 1",
               rsp0_valid, rsp_data, busy);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL lat_drain: ok=0 required 1"); end
  endtask

  task automatic test_both_after_reset();
    bit ok;
    apply_reset();
    push0(SUB, 8'h05, 8'h07, 8'hFE);
    push1(ROL, 8'h81, 8'h00, 8'h03);
    wait_drain(40, ok);
    checks++;
    if (!ok || glog.size() != 2 || rlog.size() != 2) begin
      errors++;
      $display("FAIL both_drain: ok=%b grants=%0d rsps=%0d required 1 2 2",
               ok, glog.size(), rlog.size());
    end else begin
      checks++;
      if (glog[0] != 0 || glog[1] != 1 || rlog[0] != 0 || rlog[1] != 1) begin
        errors++;
        $display("FAIL both_order: grants %0d,%0d required 0,1", glog[0], glog[1]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] ops[7] = '{NO_OP, ADD, SUB, AND, OR, XOR, ROL};
    logic [3:0] op;
    logic [7:0] a, b;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      op = ops[$urandom_range(0, 6)]; a = 8'($urandom); b = 8'($urandom);
      push0(op, a, b, alu_ref(op, a, b));
      op = ops[$urandom_range(0, 6)]; a = 8'($urandom); b = 8'($urandom);
      push1(op, a, b, alu_ref(op, a, b));
    end
    wait_drain(100, ok);
    checks++;
    if (!ok || glog.size() != 8 || rlog.size() != 8) begin
      errors++;
      $display("FAIL rr_drain: ok=%b grants=%0d rsps=%0d required 1 8 8",
               ok, glog.size(), rlog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (glog[i] != i % 2 || rlog[i] != i % 2) begin
          errors++;
          $display("FAIL rr_order[%0d]: grant=%0d rsp=%0d required %0d",
                   i, glog[i], rlog[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen = 0;
    logic [7:0] held;
    @(posedge clk); #3;
    rsp0_ready = 1'b0;
    push0(XOR, 8'h3C, 8'h55, 8'h69);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp0_valid === 1'b1) seen = 1;
    end
    held = rsp_data;
    push1(AND, 8'hF0, 8'h3C, 8'h30);
    checks++;
    if (!seen || held !== 8'h69) begin
      errors++;
      $display("FAIL bp_first: seen=%b data=%h required 1 69", seen, held);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp0_valid !== 1'b1 || rsp_data !== held ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v0=%b data=%h rdy=%b%b required 1 %h 00",
                 i, rsp0_valid, rsp_data, req0_ready, req1_ready, held);
      end
    end
    @(posedge clk); #3;
    rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy1=%b busy=%b required 1 0", req1_ready, busy);
    end
    wait_drain(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain: ok=0 required 1"); end
  endtask

  task automatic test_reset_in_exec();
    bit ok;
    bit seen = 0;
    apply_reset();
    push0(ADD, 8'h10, 8'h20, 8'h30);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) seen = 1;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_exec: seen=%b busy=%b v0=%b v1=%b required 1 0 0 0",
               seen, busy, rsp0_valid, rsp1_valid);
    end
    exp0.delete(); glog.delete();
    push1(ROL, 8'h40, 8'h00, 8'h80);
    push0(OR, 8'h0A, 8'h50, 8'h5A);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_regrant: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_drain: ok=0 required 1"); end
  endtask

  task automatic test_ops();
    bit ok;
    push0(4'hF, 8'hA5, 8'h3C, 8'hA5);
    push0(XOR, 8'hFF, 8'h0F, 8'hF0);
    push1(NO_OP, 8'h42, 8'hFF, 8'h42);
    push1(4'h3, 8'h99, 8'h11, 8'h99);
    push0(ADD, 8'hFF, 8'h02, 8'h01);
    push1(SUB, 8'h00, 8'h01, 8'hFF);
    wait_drain(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ops_drain: ok=0 required 1"); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_both_after_reset();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_ops();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
